// File: rtl/board_writer_if.sv
// Board writer command/VRAM-write bundle.
// master: command source and VRAM sink side; slave: the board_writer block.
interface board_writer_if #(
    parameter int CELL_BITS = 6
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_clear;
    logic [3:0]           cmd_x;
    logic [3:0]           cmd_y;
    logic [24:0]          cmd_shape;
    logic [CELL_BITS-1:0] cmd_color;
    logic [7:0]           wraddress;
    logic [CELL_BITS-1:0] data;
    logic                 wren;
    logic                 done;
    logic                 clipped;

    modport master (
        output cmd_valid, cmd_clear, cmd_x, cmd_y, cmd_shape, cmd_color,
        input  cmd_ready, wraddress, data, wren, done, clipped
    );

    modport slave (
        input  cmd_valid, cmd_clear, cmd_x, cmd_y, cmd_shape, cmd_color,
        output cmd_ready, wraddress, data, wren, done, clipped
    );
endinterface

// File: rtl/board_writer.sv
// board_writer: stamps a 5x5 piece bitmap onto a BOARD_W x BOARD_W board VRAM,
// one shape position per cycle, clipping bits that fall off the board.
// Optional macro BOARD_WRITER_CLEAR_EN adds a whole-board clear command.
module board_writer #(
    parameter int BOARD_W   = 14,
    parameter int CELL_BITS = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    board_writer_if.slave bus
);
    localparam logic [4:0] BW5 = 5'(BOARD_W);

`ifdef BOARD_WRITER_CLEAR_EN
    localparam logic [8:0] CELLS = 9'(BOARD_W * BOARD_W);
    typedef enum logic [1:0] {IDLE, PLACE, CLEAR, FINISH} state_t;
`else
    typedef enum logic [1:0] {IDLE, PLACE, FINISH} state_t;
`endif

    state_t               state_q;
    logic [3:0]           x_q, y_q;
    logic [24:0]          shape_q;
    logic [CELL_BITS-1:0] color_q;
    logic [4:0]           idx_q;       // shape bit index of the position evaluated next
    logic [2:0]           r_q, c_q;    // row/column of that position
    logic                 clip_acc_q;
    logic                 wren_q, done_q, clipped_q;
    logic [7:0]           addr_q;
    logic [CELL_BITS-1:0] data_q;
`ifdef BOARD_WRITER_CLEAR_EN
    logic [8:0]           clr_q;       // 9 bits so the end-of-board count cannot wrap
`else
    logic                 unused_clear;
    assign unused_clear = bus.cmd_clear;
`endif

    logic                 idle;
    logic [3:0]           ev_x, ev_y;
    logic [24:0]          ev_shape;
    logic [2:0]           ev_r, ev_c;
    logic [4:0]           ev_idx;
    logic [4:0]           col_sum, row_sum;
    logic                 ev_set, ev_on, ev_hit, ev_off;
    logic [7:0]           ev_addr;

    assign idle = (state_q == IDLE);

    // Evaluate one shape position; in IDLE it looks at the live command so the
    // first position is written on the acceptance edge itself.
    always_comb begin
        ev_x     = idle ? bus.cmd_x     : x_q;
        ev_y     = idle ? bus.cmd_y     : y_q;
        ev_shape = idle ? bus.cmd_shape : shape_q;
        ev_r     = idle ? 3'd0 : r_q;
        ev_c     = idle ? 3'd0 : c_q;
        ev_idx   = idle ? 5'd0 : idx_q;
        col_sum  = {1'b0, ev_x} + {2'b00, ev_c};
        row_sum  = {1'b0, ev_y} + {2'b00, ev_r};
        ev_on    = (col_sum < BW5) && (row_sum < BW5);
        ev_set   = ev_shape[ev_idx];
        ev_hit   = ev_set && ev_on;
        ev_off   = ev_set && !ev_on;
        ev_addr  = 8'(row_sum) * 8'(BOARD_W) + 8'(col_sum);
    end

    // Command FSM with registered VRAM write port and done/clipped strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            shape_q    <= '0;
            color_q    <= '0;
            idx_q      <= '0;
            r_q        <= '0;
            c_q        <= '0;
            clip_acc_q <= 1'b0;
            wren_q     <= 1'b0;
            done_q     <= 1'b0;
            clipped_q  <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
`ifdef BOARD_WRITER_CLEAR_EN
            clr_q      <= '0;
`endif
        end else begin
            wren_q    <= 1'b0;
            done_q    <= 1'b0;
            clipped_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        x_q     <= bus.cmd_x;
                        y_q     <= bus.cmd_y;
                        shape_q <= bus.cmd_shape;
                        color_q <= bus.cmd_color;
`ifdef BOARD_WRITER_CLEAR_EN
                        if (bus.cmd_clear) begin
                            state_q <= CLEAR;
                            wren_q  <= 1'b1;
                            addr_q  <= '0;
                            data_q  <= '0;
                            clr_q   <= 9'd1;
                        end else begin
`else
                        begin
`endif
                            state_q    <= PLACE;
                            idx_q      <= 5'd1;
                            r_q        <= 3'd0;
                            c_q        <= 3'd1;
                            clip_acc_q <= ev_off;
                            if (ev_hit) begin
                                wren_q <= 1'b1;
                                addr_q <= ev_addr;
                                data_q <= bus.cmd_color;
                            end
                        end
                    end
                end
                PLACE: begin
                    if (idx_q == 5'd25) begin
                        state_q   <= FINISH;
                        done_q    <= 1'b1;
                        clipped_q <= clip_acc_q;
                    end else begin
                        clip_acc_q <= clip_acc_q | ev_off;
                        if (ev_hit) begin
                            wren_q <= 1'b1;
                            addr_q <= ev_addr;
                            data_q <= color_q;
                        end
                        idx_q <= idx_q + 5'd1;
                        if (c_q == 3'd4) begin
                            c_q <= 3'd0;
                            r_q <= r_q + 3'd1;
                        end else begin
                            c_q <= c_q + 3'd1;
                        end
                    end
                end
`ifdef BOARD_WRITER_CLEAR_EN
                CLEAR: begin
                    if (clr_q == CELLS) begin
                        state_q <= FINISH;
                        done_q  <= 1'b1;
                    end else begin
                        wren_q <= 1'b1;
                        addr_q <= clr_q[7:0];
                        data_q <= '0;
                        clr_q  <= clr_q + 9'd1;
                    end
                end
`endif
                FINISH:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = idle;
    assign bus.wren      = wren_q;
    assign bus.wraddress = addr_q;
    assign bus.data      = data_q;
    assign bus.done      = done_q;
    assign bus.clipped   = clipped_q;
endmodule

// File: tb/tb_board_writer.sv
// Scoreboard bench for board_writer: the driver pushes expected writes/done
// events (with their cycle numbers) from a plain board model; a negedge monitor
// pops and compares whenever wren or done is seen.
module tb_board_writer;
    localparam int BW = 14;
    localparam int CB = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    board_writer_if #(.CELL_BITS(CB)) bus ();
    board_writer #(.BOARD_W(BW), .CELL_BITS(CB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int cyc;
        bit is_done;
        int addr;
        int data;
        bit clip;
    } ev_t;

    typedef struct {
        bit          clr;
        logic [3:0]  x;
        logic [3:0]  y;
        logic [24:0] shape;
        logic [5:0]  color;
    } cmd_t;

    ev_t expq[$];
    int  cyc = 0;
    int  vectors = 0;
    int  miscompares = 0;
    bit  mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void push_ev(int cy, bit d, int ad, int da, bit cl);
        ev_t e;
        e.cyc = cy; e.is_done = d; e.addr = ad; e.data = da; e.clip = cl;
        expq.push_back(e);
    endfunction

    function automatic bit is_clear(cmd_t c);
`ifdef BOARD_WRITER_CLEAR_EN
        return c.clr;
`else
        return 1'b0;
`endif
    endfunction

    // cycles from acceptance to the done pulse
    function automatic int latency(cmd_t c);
        return is_clear(c) ? BW * BW + 1 : 26;
    endfunction

    // Board model: what the block should write for a command accepted in cycle a.
    function automatic void push_model(cmd_t c, int a);
        bit clip = 1'b0;
        if (is_clear(c)) begin
            for (int i = 0; i < BW * BW; i++) push_ev(a + 1 + i, 1'b0, i, 0, 1'b0);
            push_ev(a + BW * BW + 1, 1'b1, 0, 0, 1'b0);
            return;
        end
        for (int r = 0; r < 5; r++)
            for (int cc = 0; cc < 5; cc++)
                if (c.shape[r*5+cc]) begin
                    if (int'(c.x) + cc < BW && int'(c.y) + r < BW)
                        push_ev(a + 1 + r*5 + cc, 1'b0,
                                (int'(c.y) + r) * BW + int'(c.x) + cc, int'(c.color), 1'b0);
                    else
                        clip = 1'b1;
                end
        push_ev(a + 26, 1'b1, 0, 0, clip);
    endfunction

    function automatic cmd_t rnd_cmd();
        cmd_t c;
        c.clr   = ($urandom_range(0, 7) == 0);
        c.x     = 4'($urandom_range(0, 15));
        c.y     = 4'($urandom_range(0, 15));
        c.shape = ($urandom_range(0, 1) == 1) ? 25'($urandom) : 25'($urandom & $urandom);
        c.color = 6'($urandom_range(0, 63));
        return c;
    endfunction

    function automatic cmd_t mk(bit clr, int x, int y, logic [24:0] shape, int color);
        cmd_t c;
        c.clr = clr; c.x = 4'(x); c.y = 4'(y); c.shape = shape; c.color = 6'(color);
        return c;
    endfunction

    task automatic drive(cmd_t c, bit v);
        bus.cmd_valid = v;
        bus.cmd_clear = c.clr;
        bus.cmd_x     = c.x;
        bus.cmd_y     = c.y;
        bus.cmd_shape = c.shape;
        bus.cmd_color = c.color;
    endtask

    // Called at the negedge of cycle a+1; walks to cycle a+L+1 checking ready.
    task automatic wait_busy(int a, int len);
        bit ok = 1'b1;
        while (cyc <= a + len) begin
            if (bus.cmd_ready) ok = 1'b0;
            @(negedge clk);
        end
        check("ready_low_while_busy", int'(ok), 1);
        check("ready_back", int'(bus.cmd_ready), 1);
    endtask

    task automatic send(cmd_t c, bit hold, cmd_t c2);
        int a;
        int n = 0;
        @(negedge clk);
        while (!bus.cmd_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) begin
            check("ready_timeout", 0, 1);
            return;
        end
        drive(c, 1'b1);
        a = cyc;
        push_model(c, a);
        @(negedge clk);
        // scrambled inputs after acceptance must not disturb the command
        if (hold) drive(c2, 1'b1); else drive(rnd_cmd(), 1'b0);
        wait_busy(a, latency(c));
        if (hold) begin
            a = cyc;
            push_model(c2, a);
            @(negedge clk);
            drive(rnd_cmd(), 1'b0);
            wait_busy(a, latency(c2));
        end
    endtask

    // Monitor: every write or done must match the head of the expected queue.
    always @(negedge clk) begin
        ev_t e;
        if (mon_en) begin
            if (!bus.done) check("clipped_without_done", int'(bus.clipped), 0);
            if (bus.wren || bus.done) begin
                if (expq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_output: wren=%0b done=%0b addr=%0d at cycle %0d, expected none",
                             bus.wren, bus.done, bus.wraddress, cyc);
                end else begin
                    e = expq.pop_front();
                    check("event_cycle", cyc, e.cyc);
                    check("event_is_done", int'(bus.done), int'(e.is_done));
                    if (e.is_done) begin
                        check("clipped", int'(bus.clipped), int'(e.clip));
                    end else begin
                        check("wraddress", int'(bus.wraddress), e.addr);
                        check("data", int'(bus.data), e.data);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_t c, dummy;
        int   a;
        ev_t  keep[$];
        dummy = mk(1'b0, 0, 0, 25'd0, 0);
        drive(dummy, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_wren", int'(bus.wren), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_clipped", int'(bus.clipped), 0);
        check("reset_wraddress", int'(bus.wraddress), 0);
        check("reset_data", int'(bus.data), 0);
        mon_en = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", int'(bus.cmd_ready), 1);

        // single origin bit, row 0 at (3,2), bottom-right corner with clipping
        send(mk(1'b0, 0, 0, 25'h1, 6'h15), 1'b0, dummy);
        send(mk(1'b0, 3, 2, 25'h1F, 6'h2A), 1'b0, dummy);
        send(mk(1'b0, 12, 13, 25'h27, 6'h3F), 1'b0, dummy);
        send(mk(1'b0, 15, 15, 25'h1FFFFFF, 6'h01), 1'b0, dummy);
        send(mk(1'b0, 9, 9, 25'h1FFFFFF, 6'h22), 1'b0, dummy);

        // valid held high across a whole place: second taken only when ready returns
        send(mk(1'b0, 5, 6, 25'($urandom), 6'h0C), 1'b1, mk(1'b0, 2, 1, 25'($urandom), 6'h31));

        // clear command (a place when the clear feature is not built)
        send(mk(1'b1, 4, 4, 25'h1041, 6'h17), 1'b0, dummy);

        for (int i = 0; i < 24; i++) send(rnd_cmd(), 1'b0, dummy);

        // reset in cycle 10 of a full-shape place aborts it
        @(negedge clk);
        c = mk(1'b0, 0, 0, 25'h1FFFFFF, 6'h2B);
        drive(c, 1'b1);
        a = cyc;
        push_model(c, a);
        @(negedge clk);
        drive(rnd_cmd(), 1'b0);
        while (cyc < a + 10) @(negedge clk);
        rst_n = 1'b0;
        keep = {};
        foreach (expq[i]) if (expq[i].cyc <= a + 10) keep.push_back(expq[i]);
        expq = keep;
        @(negedge clk);
        check("abort_wren", int'(bus.wren), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_wraddress", int'(bus.wraddress), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_abort", int'(bus.cmd_ready), 1);
        repeat (30) @(negedge clk);

        send(mk(1'b0, 11, 0, 25'h0108421, 6'h09), 1'b0, dummy);
        repeat (3) @(negedge clk);
        check("scoreboard_drained", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
